spi_flash_reader: RTL and testbench

- Read-only SPI NOR flash controller; sits between the CPU memory bus inside soc_top and the flash pins (spi_cs/spi_clk/spi_mosi/spi_miso).
- Each bus read becomes one SPI READ transaction returning one 32-bit little-endian word from FLASH_BASE + offset.
- Used for execute-in-place and constant fetch from the board's SPI flash.

---
 rtl/spi_flash_reader.sv | 144 ++++++++++++++
 tb/tb_spi_flash_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// Read-only SPI NOR flash bridge: each bus read becomes one READ (03h) transaction returning a little-endian word.
// Define SPI_FLASH_FAST_READ_EN to issue FAST READ (0Bh) with 8 dummy bits instead.
module spi_flash_reader #(
    parameter logic [23:0] FLASH_BASE     = 24'h500000,
    parameter int          CLK_DIV        = 1,
    parameter int          CS_HIGH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         FRAME_W    = 72;
    localparam int         DATA_START = 40;
    localparam logic [7:0] CMD        = 8'h0B;
`else
    localparam int         FRAME_W    = 64;
    localparam int         DATA_START = 32;
    localparam logic [7:0] CMD        = 8'h03;
`endif
    localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int               CNT_W     = $clog2(CS_HIGH_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CS_RELOAD = CNT_W'(CS_HIGH_CYCLES);
    localparam logic [6:0]       BIT_LAST  = 7'(FRAME_W - 1);
    localparam logic [6:0]       BIT_DATA  = 7'(DATA_START);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, DESELECT = 2'd3} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DIV_W-1:0]   r_div;
    logic               r_sclk;
    logic [6:0]         r_bit;
    logic [CNT_W-1:0]   r_desel;
    logic [FRAME_W-1:0] r_frame;
    logic [31:0]        r_rx;
    logic [31:0]        r_rdata;
    logic [FRAME_W-1:0] w_frame_init;
    logic [31:0]        w_rx_next;
    logic [23:0]        w_flash_addr;
    logic               w_accept;
    logic               w_half_end;
    logic               w_capture;
    logic               w_last_fall;
    logic               w_unused;

    // Offset is word-aligned; the 24-bit sum wraps at the top of the flash.
    assign w_flash_addr = FLASH_BASE + {mem_addr[23:2], 2'b00};
    assign w_frame_init = {CMD, w_flash_addr, {(FRAME_W - 32){1'b0}}};
    assign w_unused     = ^{mem_addr[31:24], mem_addr[1:0]};

    assign w_accept    = (r_state == IDLE) && mem_valid && (r_desel == '0);
    assign w_half_end  = (r_state == SHIFT) && (r_div == DIV_LAST);
    assign w_capture   = (r_state == SHIFT) && r_sclk && (r_div == '0) && (r_bit >= BIT_DATA);
    assign w_last_fall = w_half_end && r_sclk && (r_bit == BIT_LAST);
    assign w_rx_next   = w_capture ? {r_rx[30:0], spi_miso} : r_rx;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next = SHIFT;
            SHIFT:    if (w_last_fall) w_next = DONE;
            DONE:     w_next = DESELECT;
            DESELECT: if (r_desel <= CNT_W'(1)) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        spi_cs    = 1'b1;
        spi_clk   = 1'b0;
        spi_mosi  = 1'b0;
        mem_ready = 1'b0;
        case (r_state)
            SHIFT: begin
                spi_cs   = 1'b0;
                spi_clk  = r_sclk;
                spi_mosi = r_frame[FRAME_W-1];
            end
            DONE:    mem_ready = 1'b1;
            default: ;
        endcase
    end

    assign mem_rdata = r_rdata;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_bit   <= '0;
            r_desel <= CS_RELOAD;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_div  <= '0;
                r_sclk <= 1'b0;
                r_bit  <= '0;
            end else if (r_state == SHIFT) begin
                if (w_half_end) begin
                    r_div  <= '0;
                    r_sclk <= ~r_sclk;
                    if (r_sclk) r_bit <= r_bit + 7'd1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
            if (r_state == DONE) begin
                r_desel <= CS_RELOAD;
            end else if (r_desel != '0) begin
                r_desel <= r_desel - 1'b1;
            end
            // First received byte lands in the low byte of the bus word.
            if (w_last_fall) begin
                r_rdata <= {w_rx_next[7:0], w_rx_next[15:8], w_rx_next[23:16], w_rx_next[31:24]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_frame <= w_frame_init;
        end else if (w_half_end && r_sclk) begin
            r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
        end
        r_rx <= w_rx_next;
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
`timescale 1ns/1ps
// Bench for spi_flash_reader: two DUTs (CLK_DIV=1 at base 0x500000, CLK_DIV=2 at base 0xFFFFFC), each on a behavioural SPI flash.
module tb_spi_flash_reader;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int          FRAME   = 72;
    localparam int          DSTART  = 40;
    localparam logic [7:0]  CMD     = 8'h0B;
    localparam logic [31:0] BASIC_W = 32'hDDCCBBAA;
`else
    localparam int          FRAME   = 64;
    localparam int          DSTART  = 32;
    localparam logic [7:0]  CMD     = 8'h03;
    localparam logic [31:0] BASIC_W = 32'h00000013;
`endif
    localparam int          CSH   = 4;
    localparam logic [23:0] BASE0 = 24'h500000;
    localparam logic [23:0] BASE1 = 24'hFFFFFC;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic [1:0]       valid = '0;
    logic [31:0]      addr = '0;
    logic [1:0]       cs, sclk, mosi, rdy;
    logic [1:0]       miso = '0;
    logic [1:0][31:0] rdata;
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;

    logic [7:0]  fmem [logic [23:0]];
    int          nbits [2] = '{0, 0};
    int          frame_bits [2] = '{0, 0};
    int          mosi_bad [2] = '{0, 0};
    logic [71:0] rx [2];
    logic [31:0] hdr [2];
    logic [1:0]  prev_cs = 2'b11;
    logic [1:0]  prev_sclk = 2'b00;

    typedef struct {
        logic [31:0] data;
        logic [31:0] data_next;
        logic [31:0] hdr;
        int          t0, t_cs, t_rdy, fbits, bad;
        logic        cs_rdy, sclk_rdy, rdy_next;
    } rd_t;

    spi_flash_reader #(.FLASH_BASE(BASE0), .CLK_DIV(1), .CS_HIGH_CYCLES(CSH)) u_dut0 (
        .clk(clk), .n_reset(n_reset), .mem_valid(valid[0]), .mem_addr(addr), .mem_ready(rdy[0]),
        .mem_rdata(rdata[0]), .spi_cs(cs[0]), .spi_clk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]));

    spi_flash_reader #(.FLASH_BASE(BASE1), .CLK_DIV(2), .CS_HIGH_CYCLES(CSH)) u_dut1 (
        .clk(clk), .n_reset(n_reset), .mem_valid(valid[1]), .mem_addr(addr), .mem_ready(rdy[1]),
        .mem_rdata(rdata[1]), .spi_cs(cs[1]), .spi_clk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mbyte(input logic [23:0] a);
        if (fmem.exists(a)) return fmem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic int div_of(input int g);
        return (g == 0) ? 1 : 2;
    endfunction

    // Flash byte address from the bus offset: base plus word-aligned offset, modulo 16 MiB.
    function automatic logic [23:0] flash_addr(input int g, input logic [31:0] off);
        longint s;
        s = longint'((g == 0) ? BASE0 : BASE1) + longint'(off & 32'h00FF_FFFC);
        return 24'(s % 64'h100_0000);
    endfunction

    task automatic put_word(input logic [23:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) fmem[24'(a + 24'(k))] = w[8*k +: 8];
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SPI flash: shifts MOSI in on rising SCK, drives MISO after falling SCK, bytes from fmem.
    always @(posedge clk) begin
        int          j;
        logic [23:0] ba;
        logic [7:0]  bt;
        for (int i = 0; i < 2; i++) begin
            if (cs[i] === 1'b1) begin
                if (prev_cs[i] == 1'b0) frame_bits[i] = nbits[i];
                nbits[i] = 0;
            end else if (cs[i] === 1'b0) begin
                if (sclk[i] === 1'b1 && prev_sclk[i] == 1'b0) begin
                    if (nbits[i] >= 32 && mosi[i] !== 1'b0) mosi_bad[i]++;
                    rx[i] = {rx[i][70:0], mosi[i]};
                    nbits[i]++;
                    if (nbits[i] == 32) hdr[i] = rx[i][31:0];
                end
                if (sclk[i] === 1'b0 && prev_sclk[i] == 1'b1) begin
                    j = nbits[i] - DSTART;
                    if (j >= 0 && j < 32) begin
                        ba = hdr[i][23:0] + 24'(j / 8);
                        bt = mbyte(ba);
                        miso[i] <= bt[7 - (j % 8)];
                    end
                end
            end
            prev_cs[i]   = (cs[i] === 1'b0) ? 1'b0 : 1'b1;
            prev_sclk[i] = (sclk[i] === 1'b1) ? 1'b1 : 1'b0;
        end
    end

    task automatic do_read(input int g, input logic [31:0] a, input bit hold, input bit chg,
                           input logic [31:0] a_new, output rd_t r);
        int bad0, n;
        bad0 = mosi_bad[g];
        r.t_cs = -1; r.t_rdy = -1; r.data = 'x; r.cs_rdy = 1'bx; r.sclk_rdy = 1'bx;
        addr = a;
        valid[g] = 1'b1;
        r.t0 = cyc;
        n = 0;
        while (r.t_rdy < 0 && n < 1000) begin
            @(negedge clk);
            n++;
            if (r.t_cs < 0 && cs[g] === 1'b0) begin
                r.t_cs = cyc;
                if (chg) addr = a_new;
            end
            if (rdy[g] === 1'b1) begin
                r.t_rdy = cyc; r.data = rdata[g]; r.cs_rdy = cs[g]; r.sclk_rdy = sclk[g];
            end
        end
        @(negedge clk);
        r.rdy_next = rdy[g]; r.data_next = rdata[g];
        r.fbits = frame_bits[g]; r.bad = mosi_bad[g] - bad0; r.hdr = hdr[g];
        if (!hold) valid[g] = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        valid = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({cs[g], sclk[g], mosi[g], rdy[g]} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_pins dut%0d cs/clk/mosi/ready got %b want 1000", g, {cs[g], sclk[g], mosi[g], rdy[g]});
            end
            checks++;
            if (rdata[g] !== 32'h0) begin
                failures++;
                $display("FAIL reset_rdata dut%0d got %h want 00000000", g, rdata[g]);
            end
        end
        n_reset = 1'b1;
        repeat (CSH + 2) @(negedge clk);
    endtask

    task automatic test_basic();
        rd_t r;
        put_word(BASE0, BASIC_W);
        repeat (CSH + 2) @(negedge clk);
        do_read(0, 32'h0, 1'b0, 1'b0, 32'h0, r);
        checks++;
        if (r.t_rdy < 0) begin failures++; $display("FAIL basic_timeout no mem_ready within budget"); end
        checks++;
        if (r.hdr !== {CMD, BASE0}) begin failures++; $display("FAIL basic_mosi got %h want %h", r.hdr, {CMD, BASE0}); end
        checks++;
        if (r.data !== BASIC_W) begin failures++; $display("FAIL basic_data got %h want %h", r.data, BASIC_W); end
        checks++;
        if (r.t_cs != r.t0 + 1) begin failures++; $display("FAIL basic_cs_fall got T+%0d want T+1", r.t_cs - r.t0); end
        checks++;
        if (r.t_rdy != r.t0 + 1 + 2 * FRAME) begin failures++; $display("FAIL basic_latency got T+%0d want T+%0d", r.t_rdy - r.t0, 1 + 2 * FRAME); end
        checks++;
        if (r.cs_rdy !== 1'b1 || r.sclk_rdy !== 1'b0) begin failures++; $display("FAIL basic_pins_at_ready cs=%b clk=%b want cs=1 clk=0", r.cs_rdy, r.sclk_rdy); end
        checks++;
        if (r.rdy_next !== 1'b0) begin failures++; $display("FAIL basic_ready_width ready still %b next cycle want 0", r.rdy_next); end
        checks++;
        if (r.data_next !== BASIC_W) begin failures++; $display("FAIL basic_rdata_hold got %h want %h", r.data_next, BASIC_W); end
        checks++;
        if (r.fbits != FRAME) begin failures++; $display("FAIL basic_frame_len got %0d sck rises want %0d", r.fbits, FRAME); end
        checks++;
        if (r.bad != 0) begin failures++; $display("FAIL basic_mosi_idle got %0d high bits after address want 0", r.bad); end
    endtask

    task automatic test_align();
        rd_t         r;
        logic [31:0] offs [2];
        logic [23:0] want_a [2];
        logic [31:0] w;
        offs[0] = 32'h6;        want_a[0] = 24'h500004;
        offs[1] = 32'hFF000010; want_a[1] = 24'h500010;
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            put_word(want_a[i], w);
            do_read(0, offs[i], 1'b0, 1'b0, 32'h0, r);
            checks++;
            if (r.hdr !== {CMD, want_a[i]}) begin failures++; $display("FAIL align_addr%0d got %h want %h", i, r.hdr, {CMD, want_a[i]}); end
            checks++;
            if (r.data !== w) begin failures++; $display("FAIL align_data%0d got %h want %h", i, r.data, w); end
        end
    endtask

    task automatic test_wrap();
        rd_t         r;
        logic [31:0] w;
        w = $urandom;
        put_word(24'h000004, w);
        do_read(1, 32'h8, 1'b0, 1'b0, 32'h0, r);
        checks++;
        if (r.hdr !== {CMD, 24'h000004}) begin failures++; $display("FAIL wrap_addr got %h want %h", r.hdr, {CMD, 24'h000004}); end
        checks++;
        if (r.data !== w) begin failures++; $display("FAIL wrap_data got %h want %h", r.data, w); end
    endtask

    task automatic test_random();
        rd_t         r;
        int          g;
        logic [31:0] off, w;
        logic [23:0] a;
        for (int i = 0; i < 8; i++) begin
            g   = int'($urandom_range(0, 1));
            off = $urandom;
            w   = $urandom;
            a   = flash_addr(g, off);
            put_word(a, w);
            do_read(g, off, 1'b0, 1'b0, 32'h0, r);
            checks++;
            if (r.hdr !== {CMD, a}) begin failures++; $display("FAIL rand%0d_addr dut%0d got %h want %h", i, g, r.hdr, {CMD, a}); end
            checks++;
            if (r.data !== w) begin failures++; $display("FAIL rand%0d_data dut%0d got %h want %h", i, g, r.data, w); end
            checks++;
            if (r.t_rdy - r.t_cs != 2 * FRAME * div_of(g)) begin
                failures++;
                $display("FAIL rand%0d_latency dut%0d got %0d want %0d", i, g, r.t_rdy - r.t_cs, 2 * FRAME * div_of(g));
            end
        end
    endtask

    task automatic test_back_to_back();
        rd_t         r1, r2;
        logic [31:0] o1, o2, w1, w2;
        o1 = $urandom & 32'h00FF_FFF0;
        o2 = o1 + 32'h40;
        w1 = $urandom; w2 = $urandom;
        put_word(flash_addr(1, o1), w1);
        put_word(flash_addr(1, o2), w2);
        do_read(1, o1, 1'b1, 1'b1, o2, r1);
        do_read(1, o2, 1'b0, 1'b0, 32'h0, r2);
        checks++;
        if (r1.data !== w1) begin failures++; $display("FAIL b2b_first_data got %h want %h", r1.data, w1); end
        checks++;
        if (r2.data !== w2) begin failures++; $display("FAIL b2b_second_data got %h want %h", r2.data, w2); end
        checks++;
        if (r2.hdr !== {CMD, flash_addr(1, o2)}) begin failures++; $display("FAIL b2b_second_addr got %h want %h", r2.hdr, {CMD, flash_addr(1, o2)}); end
        checks++;
        if (r2.t_cs < 0 || r2.t_cs - r1.t_rdy < CSH + 1) begin
            failures++;
            $display("FAIL b2b_deselect gap got %0d cycles want >= %0d", r2.t_cs - r1.t_rdy, CSH + 1);
        end
        checks++;
        if (r1.rdy_next !== 1'b0 || r2.rdy_next !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_width next-cycle ready got %b%b want 00", r1.rdy_next, r2.rdy_next);
        end
    endtask

    task automatic test_drop_valid();
        logic [31:0] off, w, got;
        int          t0, t_rdy, n;
        off = $urandom; w = $urandom;
        put_word(flash_addr(0, off), w);
        repeat (CSH + 2) @(negedge clk);
        addr = off;
        valid[0] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        valid[0] = 1'b0;
        addr = $urandom;
        t_rdy = -1; got = 'x; n = 0;
        while (t_rdy < 0 && n < 500) begin
            @(negedge clk);
            n++;
            if (rdy[0] === 1'b1) begin t_rdy = cyc; got = rdata[0]; end
        end
        checks++;
        if (t_rdy != t0 + 1 + 2 * FRAME) begin failures++; $display("FAIL drop_valid_latency got %0d want %0d", t_rdy - t0, 1 + 2 * FRAME); end
        checks++;
        if (got !== w) begin failures++; $display("FAIL drop_valid_data got %h want %h", got, w); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rd_t         r;
        logic [31:0] w, off;
        int          n;
        bit          saw;
        w = $urandom | 32'h1;
        put_word(flash_addr(0, 32'h100), w);
        do_read(0, 32'h100, 1'b0, 1'b0, 32'h0, r);
        checks++;
        if (r.data !== w) begin failures++; $display("FAIL rstmid_prime_data got %h want %h", r.data, w); end
        addr = 32'h200;
        valid[0] = 1'b1;
        n = 0;
        while (nbits[0] < 20 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (nbits[0] != 20) begin failures++; $display("FAIL rstmid_reach_bit got %0d want 20", nbits[0]); end
        #2 n_reset = 1'b0;
        #1;
        checks++;
        if ({cs[0], sclk[0], mosi[0], rdy[0]} !== 4'b1000) begin
            failures++;
            $display("FAIL rstmid_async_pins cs/clk/mosi/ready got %b want 1000", {cs[0], sclk[0], mosi[0], rdy[0]});
        end
        checks++;
        if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin failures++; $display("FAIL rstmid_rdata got %h/%h want 0/0", rdata[0], rdata[1]); end
        valid[0] = 1'b0;
        saw = 1'b0;
        repeat (3) begin @(negedge clk); if (rdy[0] !== 1'b0) saw = 1'b1; end
        checks++;
        if (saw) begin failures++; $display("FAIL rstmid_no_ready got a ready pulse want none"); end
        n_reset = 1'b1;
        off = $urandom; w = $urandom;
        put_word(flash_addr(0, off), w);
        do_read(0, off, 1'b0, 1'b0, 32'h0, r);
        checks++;
        if (r.hdr !== {CMD, flash_addr(0, off)}) begin failures++; $display("FAIL rstmid_restart_addr got %h want %h", r.hdr, {CMD, flash_addr(0, off)}); end
        checks++;
        if (r.data !== w) begin failures++; $display("FAIL rstmid_restart_data got %h want %h", r.data, w); end
        checks++;
        if (r.fbits != FRAME) begin failures++; $display("FAIL rstmid_restart_len got %0d want %0d", r.fbits, FRAME); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_align();
        test_wrap();
        test_random();
        test_back_to_back();
        test_drop_valid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
